// File: rtl/cp0_unit.sv
// Coprocessor-0 for the pipelined MIPS core: SR/Cause/EPC/PRId storage,
// exception/interrupt request generation and eret handling in the M stage.
module cp0_unit #(
  parameter logic [31:0] PRID         = 32'h0000_2004,
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_in,
  input  logic [31:0] vpc,
  input  logic        bd_in,
  input  logic [4:0]  exc_in,
  input  logic        eret_in,
  input  logic [5:0]  hw_int,
  output logic [31:0] cp0_out,
  output logic [31:0] epc_out,
  output logic [31:0] handler_pc,
  output logic        req
);

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

  logic [5:0]  im;
  logic        exl;
  logic        ie;
  logic        bd;
  logic [5:0]  ip;
  logic [4:0]  exc_code;
  logic [31:0] epc;

  logic        int_req;
  logic        exc_req;
  logic [31:0] vpc_aligned;
  logic [31:0] epc_next;

  // Interrupts win over exceptions; EXL blocks both so nesting never happens.
  always_comb begin
    int_req     = (|(hw_int & im)) & ie & ~exl;
    exc_req     = (exc_in != 5'd0) & ~exl;
    req         = ~reset & (int_req | exc_req);
    vpc_aligned = vpc & ~32'd3;
    epc_next    = bd_in ? (vpc_aligned - 32'd4) : vpc_aligned;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      im       <= '0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      bd       <= 1'b0;
      ip       <= '0;
      exc_code <= '0;
      epc      <= '0;
    end else begin
      ip <= hw_int;
      if (req) begin
        exl      <= 1'b1;
        bd       <= bd_in;
        exc_code <= int_req ? 5'd0 : exc_in;
        epc      <= epc_next;
      end else begin
        if (eret_in) exl <= 1'b0;
        // A write to SR lands after eret so mtc0 data wins if both ever appear.
        if (en) begin
          case (cp0_addr)
            ADDR_SR: begin
              im  <= cp0_in[15:10];
              exl <= cp0_in[1];
              ie  <= cp0_in[0];
            end
            ADDR_EPC: epc <= cp0_in;
            default: ;
          endcase
        end
      end
    end
  end

  always_comb begin
    cp0_out = '0;
    case (cp0_addr)
      ADDR_SR:    cp0_out = {16'b0, im, 8'b0, exl, ie};
      ADDR_CAUSE: cp0_out = {bd, 15'b0, ip, 3'b0, exc_code, 2'b0};
      ADDR_EPC:   cp0_out = epc;
      ADDR_PRID:  cp0_out = PRID;
      default:    cp0_out = '0;
    endcase
  end

  // Forward an mtc0 EPC still in M so a back-to-back eret sees the new target.
  assign epc_out    = (en && cp0_addr == ADDR_EPC) ? cp0_in : epc;
  assign handler_pc = HANDLER_ADDR;

endmodule

// File: tb/tb_cp0_unit.sv
// Self-checking bench for cp0_unit: directed test-plan steps followed by
// random traffic, all compared against a word-level reference model.
module tb_cp0_unit;

  localparam logic [31:0] PRID_VAL    = 32'h0000_2004;
  localparam logic [31:0] HANDLER_VAL = 32'h0000_4180;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_in;
  logic [31:0] vpc;
  logic        bd_in;
  logic [4:0]  exc_in;
  logic        eret_in;
  logic [5:0]  hw_int;
  logic [31:0] cp0_out;
  logic [31:0] epc_out;
  logic [31:0] handler_pc;
  logic        req;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_sr;
  logic [31:0] m_cause;
  logic [31:0] m_epc;
  bit          model_valid = 1'b0;

  logic        obs_req;
  logic [31:0] obs_out;
  logic [31:0] obs_epc_out;

  always #5 clk = ~clk;

  cp0_unit dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .cp0_addr   (cp0_addr),
    .cp0_in     (cp0_in),
    .vpc        (vpc),
    .bd_in      (bd_in),
    .exc_in     (exc_in),
    .eret_in    (eret_in),
    .hw_int     (hw_int),
    .cp0_out    (cp0_out),
    .epc_out    (epc_out),
    .handler_pc (handler_pc),
    .req        (req)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic model_int();
    return ((hw_int & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic logic model_req();
    if (reset) return 1'b0;
    return model_int() || ((exc_in != 5'd0) && !m_sr[1]);
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return PRID_VAL;
      default: return 32'd0;
    endcase
  endfunction

  // Register words updated from the architectural rules at a clock edge.
  task automatic model_edge();
    logic        irq;
    logic [31:0] ip_word;
    if (reset) begin
      m_sr    = 32'd0;
      m_cause = 32'd0;
      m_epc   = 32'd0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      irq     = model_int();
      ip_word = {16'd0, hw_int, 10'd0};
      if (model_req()) begin
        m_sr    = m_sr | 32'd2;
        m_cause = {bd_in, 31'd0} | ip_word | (irq ? 32'd0 : ({27'd0, exc_in} << 2));
        m_epc   = (vpc & ~32'd3) - (bd_in ? 32'd4 : 32'd0);
      end else begin
        m_cause = (m_cause & ~32'h0000_FC00) | ip_word;
        if (eret_in) m_sr = m_sr & ~32'd2;
        if (en && cp0_addr == 5'd12) m_sr = cp0_in & 32'h0000_FC03;
        if (en && cp0_addr == 5'd14) m_epc = cp0_in;
      end
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic wr, input logic [4:0] addr,
                               input logic [31:0] din, input logic [31:0] pc, input logic bd,
                               input logic [4:0] exc, input logic er, input logic [5:0] hw);
    reset    = rst;
    en       = wr;
    cp0_addr = addr;
    cp0_in   = din;
    vpc      = pc;
    bd_in    = bd;
    exc_in   = exc;
    eret_in  = er;
    hw_int   = hw;
    #1;
    obs_req     = req;
    obs_out     = cp0_out;
    obs_epc_out = epc_out;
    if (model_valid) begin
      checkOutput("req", {31'd0, req}, {31'd0, model_req()});
      checkOutput("cp0_out", cp0_out, model_read(addr));
      checkOutput("epc_out", epc_out, (wr && addr == 5'd14) ? din : m_epc);
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    // Reset and idle reads
    applyStimulus(1, 0, 5'd0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 5'd0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 5'd12, 0, 0, 0, 0, 0, 0);
    checkOutput("rst_sr", obs_out, 32'd0);
    checkOutput("rst_req", {31'd0, obs_req}, 32'd0);
    checkOutput("rst_epc_out", obs_epc_out, 32'd0);
    applyStimulus(0, 0, 5'd13, 0, 0, 0, 0, 0, 0);
    checkOutput("rst_cause", obs_out, 32'd0);
    applyStimulus(0, 0, 5'd14, 0, 0, 0, 0, 0, 0);
    checkOutput("rst_epc", obs_out, 32'd0);
    applyStimulus(0, 0, 5'd15, 0, 0, 0, 0, 0, 0);
    checkOutput("prid", obs_out, PRID_VAL);
    checkOutput("handler_pc", handler_pc, HANDLER_VAL);

    // SR write masking, Cause read-only
    applyStimulus(0, 1, 5'd12, 32'hFFFF_FFFF, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 5'd12, 0, 0, 0, 0, 0, 0);
    checkOutput("sr_mask", obs_out, 32'h0000_FC03);
    applyStimulus(0, 1, 5'd13, 32'hFFFF_FFFF, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 5'd13, 0, 0, 0, 0, 0, 0);
    checkOutput("cause_ro", obs_out, 32'd0);

    // Interrupt entry
    applyStimulus(0, 1, 5'd12, 32'h0000_0401, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 5'd0, 0, 32'h3010, 0, 0, 0, 6'b000001);
    checkOutput("int_req", {31'd0, obs_req}, 32'd1);
    applyStimulus(0, 0, 5'd14, 0, 32'h3010, 0, 0, 0, 6'b000001);
    checkOutput("int_epc", obs_out, 32'h3010);
    checkOutput("int_req_drop", {31'd0, obs_req}, 32'd0);
    applyStimulus(0, 0, 5'd13, 0, 0, 0, 0, 0, 6'b000001);
    checkOutput("int_cause", obs_out, 32'h0000_0400);
    applyStimulus(0, 0, 5'd12, 0, 0, 0, 0, 0, 0);
    checkOutput("int_sr_exl", obs_out, 32'h0000_0403);

    // Exception in a branch delay slot
    applyStimulus(0, 1, 5'd12, 32'd0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 5'd0, 0, 32'h3024, 1, 5'd4, 0, 0);
    checkOutput("exc_req", {31'd0, obs_req}, 32'd1);
    applyStimulus(0, 0, 5'd14, 0, 0, 0, 0, 0, 0);
    checkOutput("exc_epc_bd", obs_out, 32'h3020);
    applyStimulus(0, 0, 5'd13, 0, 0, 0, 0, 0, 0);
    checkOutput("exc_cause", obs_out, 32'h8000_0010);

    // EXL blocks nesting; eret reopens
    applyStimulus(0, 0, 5'd0, 0, 0, 0, 5'd10, 0, 0);
    checkOutput("exl_block", {31'd0, obs_req}, 32'd0);
    applyStimulus(0, 1, 5'd12, 32'h0000_0403, 0, 0, 5'd10, 0, 6'b000001);
    checkOutput("exl_block_int", {31'd0, obs_req}, 32'd0);
    applyStimulus(0, 0, 5'd0, 0, 0, 0, 0, 1, 6'b000001);
    checkOutput("eret_cycle", {31'd0, obs_req}, 32'd0);
    applyStimulus(0, 0, 5'd12, 0, 32'h3040, 0, 0, 0, 6'b000001);
    checkOutput("post_eret_req", {31'd0, obs_req}, 32'd1);
    checkOutput("post_eret_sr", obs_out, 32'h0000_0401);

    // mtc0 EPC racing an interrupt, then without one
    applyStimulus(0, 0, 5'd0, 0, 0, 0, 0, 1, 0);
    applyStimulus(0, 1, 5'd14, 32'h3400, 32'h3050, 0, 0, 0, 6'b000001);
    checkOutput("race_req", {31'd0, obs_req}, 32'd1);
    checkOutput("race_bypass", obs_epc_out, 32'h3400);
    applyStimulus(0, 0, 5'd14, 0, 0, 0, 0, 0, 0);
    checkOutput("race_epc", obs_out, 32'h3050);
    applyStimulus(0, 0, 5'd0, 0, 0, 0, 0, 1, 0);
    applyStimulus(0, 1, 5'd14, 32'h3400, 0, 0, 0, 0, 0);
    checkOutput("bypass_req", {31'd0, obs_req}, 32'd0);
    checkOutput("bypass_epc_out", obs_epc_out, 32'h3400);
    applyStimulus(0, 0, 5'd14, 0, 0, 0, 0, 0, 0);
    checkOutput("mtc0_epc", obs_out, 32'h3400);

    // Interrupt withdrawn, then reset overriding a live request
    applyStimulus(0, 0, 5'd0, 0, 0, 0, 0, 0, 0);
    checkOutput("int_withdrawn", {31'd0, obs_req}, 32'd0);
    applyStimulus(1, 1, 5'd12, 32'h0000_0401, 0, 0, 5'd3, 0, 6'b000001);
    checkOutput("reset_override", {31'd0, obs_req}, 32'd0);
    applyStimulus(0, 0, 5'd14, 0, 0, 0, 0, 0, 0);
    checkOutput("reset_epc", obs_out, 32'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic        r_rst, r_en, r_eret, r_bd;
      logic [4:0]  r_addr, r_exc;
      logic [5:0]  r_hw;
      logic [31:0] r_din, r_pc;
      r_rst  = ($urandom_range(0, 31) == 0);
      r_en   = ($urandom_range(0, 3) == 0);
      r_eret = !r_en && ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 5))
        0: r_addr = 5'd12;
        1: r_addr = 5'd13;
        2: r_addr = 5'd14;
        3: r_addr = 5'd15;
        default: r_addr = 5'($urandom);
      endcase
      r_exc = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0;
      r_hw  = 6'($urandom) & 6'($urandom);
      r_din = $urandom;
      r_pc  = $urandom;
      r_bd  = 1'($urandom);
      applyStimulus(r_rst, r_en, r_addr, r_din, r_pc, r_bd, r_exc, r_eret, r_hw);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cp0_unit.md
# cp0_unit

Coprocessor-0 for the exception-capable pipelined MIPS core, placed in the M stage directly downstream of the E/M pipeline register. It consumes the M-stage PC, branch-delay flag and accumulated exception code from that register together with the external hardware interrupt lines. It decides whether an exception or interrupt is taken this cycle and drives `req` back to every pipeline register to flush. It also holds SR, Cause, EPC and PRId, serving `mtc0`, `mfc0` and `eret`.

## Interface
- `PRID`, 32'h0000_2004: read-only value of register 15.
- `HANDLER_ADDR`, 32'h0000_4180: exception entry PC presented on `handler_pc`.
- `clk`  in  1: system clock; all state updates on its rising edge.
- `reset`  in  1: reset is synchronous and active-high.
- `en`  in  1: `mtc0` write strobe from M stage.
- `cp0_addr`  in  5: register number for read and write; only 12, 13, 14 and 15 are implemented.
- `cp0_in`  in  32: `mtc0` write data.
- `vpc`  in  32: PC of the instruction currently in M.
- `bd_in`  in  1: the M-stage instruction sits in a branch delay slot.
- `exc_in`  in  5: ExcCode carried down the pipe; 0 means no exception.
- `eret_in`  in  1: `eret` is in M.
- `hw_int`  in  6: hardware interrupt lines, level sensitive.
- `cp0_out`  out  32: `mfc0` read data, combinational from `cp0_addr`.
- `epc_out`  out  32: EPC value used as the `eret` target.
- `handler_pc`  out  32: constant `HANDLER_ADDR`.
- `req`  out  1: exception or interrupt taken this cycle; flushes all stage registers.

## Operation
- SR (12) fields: IM = bits 15:10, EXL = bit 1, IE = bit 0.
  - All other bits read as 0.
  - `mtc0` writes only the IM, EXL and IE fields.
- Cause (13) fields: BD = bit 31, IP = bits 15:10, ExcCode = bits 6:2.
  - All other bits read as 0.
  - Cause is read-only to `mtc0`.
- EPC (14): 32 bits, fully writable by `mtc0`.
- PRId (15): reads `PRID`; writes are ignored.
- Unimplemented addresses read as 0; writes to them are ignored.
- Request logic:
  - `int_req = |(hw_int & IM) & IE & ~EXL`
  - `exc_req = (exc_in != 0) & ~EXL`
  - `req = int_req | exc_req`, forced to 0 while `reset` is high.
- Interrupt has priority over exception. On `int_req`, ExcCode records 0 and `exc_in` is discarded.
- On `req` at the clock edge:
  - EXL ← 1.
  - BD ← `bd_in`.
  - ExcCode ← 0 for an interrupt, otherwise `exc_in`.
  - EPC ← `bd_in ? {vpc[31:2],2'b00} - 4 : {vpc[31:2],2'b00}`.
  - Any `mtc0` and `eret` presented in the same cycle are suppressed.
- IP ← `hw_int` on every non-reset edge, including edges where `req` is high.
- On `eret_in` without `req`: EXL ← 0.
- On `en` without `req`: the addressed register is written per the masks above.
- `eret_in` and `en` together cannot occur, because they come from a single instruction. If they do occur, both take effect.
- EPC bypass: `epc_out = (en && cp0_addr==14) ? cp0_in : EPC`. This covers an `mtc0 EPC` in M in the same cycle.
- `cp0_out` has no bypass. It returns register contents as of the last edge.

## Timing
- Reset, at the edge with `reset`=1:
  - SR = 0, Cause = 0, EPC = 0.
  - Resulting outputs: `req` = 0, `cp0_out` = 0 for addresses 12–14, `epc_out` = 0.
- `req` is combinational, in the same cycle that the faulting instruction or enabling interrupt is in M.
- Architectural updates land at the following rising edge.
- `eret` clears EXL at the edge ending its M cycle. A pending interrupt may then raise `req` in the next cycle.
- While EXL = 1, `req` stays 0 regardless of `hw_int` or `exc_in`. Nested exceptions are not taken.
- `hw_int` deasserting before the edge withdraws `int_req`; no latching occurs.
- `reset` overrides any simultaneous `req`, `en` or `eret_in`.

## Test plan
- Reset, then read addresses 12–15 → 0, 0, 0, `PRID`. `req` = 0 with `exc_in` = 0.
- `mtc0` SR with `cp0_in` = 32'hFFFF_FFFF, then read SR → 32'h0000_FC03.
  - Then `mtc0` Cause with 32'hFFFF_FFFF → Cause is unchanged.
- SR = 32'h0000_0401, `hw_int` = 6'b000001, `vpc` = 32'h3010, `bd_in` = 0:
  - `req` = 1 in the same cycle.
  - After the edge: EPC = 32'h3010, ExcCode = 0, EXL = 1, IP = 6'b000001.
  - `req` = 0 in the next cycle.
- SR = 0, `exc_in` = 5'd4, `vpc` = 32'h3024, `bd_in` = 1:
  - `req` = 1.
  - After the edge: EPC = 32'h3020, BD = 1, ExcCode = 4.
- EXL = 1 with `exc_in` = 5'd10 → `req` stays 0.
  - `eret_in` = 1 for one cycle → EXL = 0.
  - With IE = 1 and IM[0] = 1 and `hw_int` still 6'b000001 → `req` = 1 in the following cycle.
- `mtc0` EPC with `cp0_in` = 32'h3400 in the same cycle as an interrupt `req`:
  - The write is suppressed; EPC = `vpc` after the edge.
  - Without `req`: `epc_out` = 32'h3400 in that same cycle.
